// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state type and counter sizing for the alarm beeper.
package alarm_pkg;
  typedef enum logic [2:0] {IDLE, BEEP_ON, BEEP_OFF, GAP, SNOOZE} beeper_state_t;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/alarm_beeper_tone_gen.sv
// tone_gen: registered square-wave divider; restart begins a fresh high half-period.
module tone_gen
  import alarm_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic square
);
  localparam int W = cnt_width(HALF);
  localparam logic [W-1:0] RELOAD = W'(HALF - 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d;
  always_comb begin
    cnt_d = (restart || cnt_q == '0) ? RELOAD : cnt_q - W'(1);
    sq_d = !enable ? 1'b0 : restart ? 1'b1 : (cnt_q == '0) ? !sq_q : sq_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      sq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q <= sq_d;
    end
  assign square = sq_q;
endmodule

// File: rtl/alarm_beeper.sv
// alarm_beeper: turns an alarm trigger into beep bursts with dismiss, snooze and timeout.
module alarm_beeper
  import alarm_pkg::*;
#(
  parameter int BEEP_ON_CYCLES   = 250,
  parameter int BEEP_OFF_CYCLES  = 250,
  parameter int BEEPS_PER_BURST  = 4,
  parameter int BURST_GAP_CYCLES = 1000,
  parameter int TIMEOUT_BURSTS   = 60,
  parameter int SNOOZE_CYCLES    = 300000,
  parameter int MAX_SNOOZES      = 3,
  parameter int TONE_HALF_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  input  logic dismiss,
  input  logic snooze,
  output logic buzzer,
  output logic active,
  output logic snoozing,
  output logic timed_out
);
  localparam int M1 = BEEP_ON_CYCLES > BEEP_OFF_CYCLES ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
  localparam int M2 = BURST_GAP_CYCLES > SNOOZE_CYCLES ? BURST_GAP_CYCLES : SNOOZE_CYCLES;
  localparam int CW = cnt_width(M1 > M2 ? M1 : M2);
  localparam int BW = cnt_width(BEEPS_PER_BURST);
  localparam int TW = cnt_width(TIMEOUT_BURSTS);
  localparam int SW = cnt_width(MAX_SNOOZES + 1);
  localparam logic [CW-1:0] ON_LD = CW'(BEEP_ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LD = CW'(BEEP_OFF_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(BURST_GAP_CYCLES - 1);
  localparam logic [CW-1:0] SNZ_LD = CW'(SNOOZE_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BEEP = BW'(BEEPS_PER_BURST - 1);
  localparam logic [TW-1:0] LAST_BURST = TW'(TIMEOUT_BURSTS - 1);
  localparam logic [SW-1:0] SNZ_MAX = SW'(MAX_SNOOZES);
  beeper_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] beep_idx_q, beep_idx_d;
  logic [TW-1:0] burst_cnt_q, burst_cnt_d;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic timed_out_q, timed_out_d;
  logic active_q, snoozing_q;
  logic tone_en, tone_restart;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    beep_idx_d = beep_idx_q;
    burst_cnt_d = burst_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    timed_out_d = timed_out_q;
    if (state_q == IDLE) begin
      if (trigger && !dismiss) begin
        state_d = BEEP_ON;
        cnt_d = ON_LD;
        beep_idx_d = '0;
        burst_cnt_d = '0;
        snooze_cnt_d = '0;
        timed_out_d = 1'b0;
      end
    end else if (dismiss) begin
      state_d = IDLE;
    end else if (snooze && state_q != SNOOZE && snooze_cnt_q < SNZ_MAX) begin
      state_d = SNOOZE;
      cnt_d = SNZ_LD;
      snooze_cnt_d = snooze_cnt_q + SW'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      case (state_q)
        BEEP_ON: begin
          state_d = (beep_idx_q == LAST_BEEP) ? GAP : BEEP_OFF;
          cnt_d = (beep_idx_q == LAST_BEEP) ? GAP_LD : OFF_LD;
        end
        BEEP_OFF: begin
          state_d = BEEP_ON;
          cnt_d = ON_LD;
          beep_idx_d = beep_idx_q + BW'(1);
        end
        GAP: begin
          if (burst_cnt_q == LAST_BURST) begin
            state_d = IDLE;
            timed_out_d = 1'b1;
          end else begin
            state_d = BEEP_ON;
            cnt_d = ON_LD;
            burst_cnt_d = burst_cnt_q + TW'(1);
            beep_idx_d = '0;
          end
        end
        default: begin
          // snooze expiry restarts the timeout window from the first burst
          state_d = BEEP_ON;
          cnt_d = ON_LD;
          beep_idx_d = '0;
          burst_cnt_d = '0;
        end
      endcase
    end
  end
  assign tone_en = (state_d == BEEP_ON);
  assign tone_restart = tone_en && state_q != BEEP_ON;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      beep_idx_q <= '0;
      burst_cnt_q <= '0;
      snooze_cnt_q <= '0;
      timed_out_q <= 1'b0;
      active_q <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      beep_idx_q <= beep_idx_d;
      burst_cnt_q <= burst_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      timed_out_q <= timed_out_d;
      active_q <= (state_d != IDLE);
      snoozing_q <= (state_d == SNOOZE);
    end
  tone_gen #(.HALF(TONE_HALF_CYCLES)) u_tone (
    .clk(clk),
    .reset(reset),
    .enable(tone_en),
    .restart(tone_restart),
    .square(buzzer)
  );
  assign active = active_q;
  assign snoozing = snoozing_q;
  assign timed_out = timed_out_q;
endmodule
